hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core. It sits beside the forwarding control unit and covers the hazards that forwarding cannot resolve: load-use, ID-stage branch-compare dependencies, and a multi-cycle multiply/divide unit.
- It drives PC/IF-ID write enables, ID/EX bubble insertion and IF/ID flush on taken control transfers.
- It tracks multiply/divide occupancy with a countdown counter and keeps a saturating stall-cycle performance counter.

Parameters:
- MULDIV_LATENCY, 32, cycles from multiply/divide issue until HI/LO are valid; legal range ≥1.
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- Clk  in  1  clock.
- Rst  in  1  synchronous, active-high reset.
- Rs_ID, Rt_ID  in  5 each  source registers of the instruction in ID.
- UsesRs_ID, UsesRt_ID  in  1 each  the ID instruction actually reads Rs/Rt.
- Branch_ID  in  1  ID instruction is a beq/bne compared in ID.
- BranchTaken_ID  in  1  ID compare result is taken, or the instruction is a jump.
- MulDivStart_ID  in  1  ID instruction is mult/multu/div/divu.
- HiLoRead_ID  in  1  ID instruction is mfhi/mflo.
- WriteRegAddress_EX, WriteRegAddress_MEM  in  5 each  destination registers.
- RegWrite_EX, RegWrite_MEM  in  1 each  register-write enables.
- MemRead_EX, MemRead_MEM  in  1 each  the instruction in that stage is a load.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID register load enable.
- IDEXFlush  out  1  replace the ID/EX contents with a bubble.
- IFIDFlush  out  1  clear IF/ID (squash the fetched instruction).
- MulDivBusy  out  1  multiply/divide in flight.
- StallCause  out  2  0 none, 1 load-use, 2 branch dependency, 3 mul/div busy.
- StallCycles  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset is synchronous and active-high.
  - The `MdCnt` register and StallCycles clear to 0 on the first rising Clk edge with Rst=1.
  - While Rst=1, outputs are forced: PCWrite=0, IFIDWrite=0, IDEXFlush=1, IFIDFlush=1, StallCause=0.
  - Reset mid-multiply aborts the countdown; MulDivBusy=0 in the cycle after reset is sampled.
- Register match rule: a match requires equal addresses, a nonzero address, and the corresponding RegWrite=1. Register $0 never causes a hazard.
- LoadUse = MemRead_EX and a match of WriteRegAddress_EX with (UsesRs_ID and Rs_ID) or (UsesRt_ID and Rt_ID).
- BrHaz = Branch_ID and either:
  - a match of WriteRegAddress_EX with Rs_ID/Rt_ID (ALU result not ready in ID), or
  - MemRead_MEM and a match of WriteRegAddress_MEM with Rs_ID/Rt_ID.
- MdHaz = (MulDivStart_ID or HiLoRead_ID) and MdCnt≠0.
- Stall = LoadUse or BrHaz or MdHaz. All three terms are combinational, with zero latency.
- StallCause priority is LoadUse > BrHaz > MdHaz; StallCause=0 when Stall=0.
- Stall=1 drives PCWrite=0, IFIDWrite=0, IDEXFlush=1.
- Stall=0 drives PCWrite=1, IFIDWrite=1, IDEXFlush=0.
- IFIDFlush = BranchTaken_ID and not Stall. A taken branch that is stalled does not flush; it is re-evaluated on the next cycle.
- Multiply/divide counter `MdCnt`, width clog2(MULDIV_LATENCY+1):
  - Issue means MulDivStart_ID=1 and Stall=0. On issue, MdCnt is loaded with MULDIV_LATENCY at the next edge.
  - Otherwise, if MdCnt≠0, it decrements by 1. Otherwise it holds at 0.
  - Issue with MdCnt≠0 cannot occur, because MdHaz stalls it.
  - MulDivBusy = (MdCnt≠0), registered-derived.
- Consequence: mfhi directly behind mult stalls exactly MULDIV_LATENCY cycles. Independent instructions never stall on MdCnt.
- StallCycles increments on every edge with Rst=0 and Stall=1. It saturates at 2^CNT_W−1 with no wrap.
- Simultaneous events: load-use plus taken branch gives stall only, no flush. Mul/div issue in a stalled cycle (e.g. load-use on its operand) does not load MdCnt.

Test Plan:
- Load-use: MemRead_EX=1, RegWrite_EX=1, WriteRegAddress_EX=8, Rs_ID=8, UsesRs_ID=1 -> PCWrite=0, IFIDWrite=0, IDEXFlush=1, StallCause=1, StallCycles 0→1. Repeat with address 0 -> no stall.
- Branch dependency: Branch_ID=1, Rt_ID=9, RegWrite_EX=1, WriteRegAddress_EX=9 -> stall, cause 2. Next cycle, the producer is in MEM as a non-load and the producer's destination no longer matches WriteRegAddress_EX -> no stall. If the producer in MEM is a load (MemRead_MEM=1) -> exactly 2 stall cycles.
- Taken branch: BranchTaken_ID=1 with no hazard -> IFIDFlush=1 for 1 cycle, PCWrite=1. Same with LoadUse active -> IFIDFlush=0.
- Mul/div: MULDIV_LATENCY=4, mult issues at cycle 0, mfhi in ID at cycle 1 -> stall for cycles 1–4, StallCause=3, MulDivBusy high for cycles 1–4, mfhi proceeds at cycle 5. An independent add at cycle 1 -> no stall.
- Reset mid-operation: assert Rst at cycle 2 of a LATENCY=4 countdown -> MdCnt=0, MulDivBusy=0 after the edge, StallCycles=0, forced reset outputs while Rst=1.
- Saturation: CNT_W=3, hold Stall=1 for 10 cycles -> StallCycles reaches 7 and stays at 7.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: detects hazards forwarding cannot cover (load-use,
// ID-stage branch operands, busy multiply/divide) and drives stall, bubble and flush controls.
module hazard_stall_controller #(
  parameter int MULDIV_LATENCY = 32,
  parameter int CNT_W          = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       Rs_ID,
  input  logic [4:0]       Rt_ID,
  input  logic             UsesRs_ID,
  input  logic             UsesRt_ID,
  input  logic             Branch_ID,
  input  logic             BranchTaken_ID,
  input  logic             MulDivStart_ID,
  input  logic             HiLoRead_ID,
  input  logic [4:0]       WriteRegAddress_EX,
  input  logic [4:0]       WriteRegAddress_MEM,
  input  logic             RegWrite_EX,
  input  logic             RegWrite_MEM,
  input  logic             MemRead_EX,
  input  logic             MemRead_MEM,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXFlush,
  output logic             IFIDFlush,
  output logic             MulDivBusy,
  output logic [1:0]       StallCause,
  output logic [CNT_W-1:0] StallCycles
);

  localparam int MD_W = $clog2(MULDIV_LATENCY + 1);

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_LOAD_USE = 2'd1,
    CAUSE_BRANCH   = 2'd2,
    CAUSE_MULDIV   = 2'd3
  } cause_e;

  logic [MD_W-1:0] md_cnt;
  logic            load_use;
  logic            br_haz;
  logic            md_haz;
  logic            stall;
  cause_e          cause;

  // Register $0 is hardwired to zero, so it never carries a dependency.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src,
                                     input logic we);
    return we && (dst != 5'd0) && (dst == src);
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    load_use = 1'b0;
    br_haz   = 1'b0;
    md_haz   = 1'b0;
    cause    = CAUSE_NONE;

    load_use = MemRead_EX &&
               ((UsesRs_ID && reg_match(WriteRegAddress_EX, Rs_ID, RegWrite_EX)) ||
                (UsesRt_ID && reg_match(WriteRegAddress_EX, Rt_ID, RegWrite_EX)));

    br_haz = Branch_ID &&
             (reg_match(WriteRegAddress_EX, Rs_ID, RegWrite_EX) ||
              reg_match(WriteRegAddress_EX, Rt_ID, RegWrite_EX) ||
              (MemRead_MEM && (reg_match(WriteRegAddress_MEM, Rs_ID, RegWrite_MEM) ||
                               reg_match(WriteRegAddress_MEM, Rt_ID, RegWrite_MEM))));

    md_haz = (MulDivStart_ID || HiLoRead_ID) && (md_cnt != '0);

    if (load_use)    cause = CAUSE_LOAD_USE;
    else if (br_haz) cause = CAUSE_BRANCH;
    else if (md_haz) cause = CAUSE_MULDIV;
  end

  assign stall = load_use || br_haz || md_haz;

  always_comb begin
    PCWrite    = !stall;
    IFIDWrite  = !stall;
    IDEXFlush  = stall;
    IFIDFlush  = BranchTaken_ID && !stall;
    StallCause = cause;
    // Hold the pipeline frozen and empty for as long as reset is asserted.
    if (Rst) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXFlush  = 1'b1;
      IFIDFlush  = 1'b1;
      StallCause = CAUSE_NONE;
    end
  end

  // A stalled mul/div does not issue, so the countdown only starts once it leaves ID.
  always_ff @(posedge Clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (Rst)
      md_cnt <= '0;
    else if (MulDivStart_ID && !stall)
      md_cnt <= MD_W'(MULDIV_LATENCY);
    else if (md_cnt != '0)
      md_cnt <= md_cnt - 1'b1;
  end

  assign MulDivBusy = (md_cnt != '0);

  always_ff @(posedge Clk) begin
    if (Rst)
      StallCycles <= '0;
    else if (stall && (StallCycles != '1))
      StallCycles <= StallCycles + 1'b1;
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: hand-computed vectors for each hazard class,
// flush gating, mul/div countdown, mid-operation reset and counter saturation.
module tb_hazard_stall_controller;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [4:0]  Rs_ID, Rt_ID, WriteRegAddress_EX, WriteRegAddress_MEM;
  logic        UsesRs_ID, UsesRt_ID, Branch_ID, BranchTaken_ID, MulDivStart_ID, HiLoRead_ID;
  logic        RegWrite_EX, RegWrite_MEM, MemRead_EX, MemRead_MEM;
  logic        PCWrite, IFIDWrite, IDEXFlush, IFIDFlush, MulDivBusy;
  logic [1:0]  StallCause;
  logic [31:0] StallCycles;
  logic        sat_pc_write, sat_ifid_write, sat_idex_flush, sat_ifid_flush, sat_busy;
  logic [1:0]  sat_cause;
  logic [2:0]  sat_cycles;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  hazard_stall_controller #(.MULDIV_LATENCY(4), .CNT_W(32)) dut (
    .Clk(Clk), .Rst(Rst), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
    .UsesRs_ID(UsesRs_ID), .UsesRt_ID(UsesRt_ID), .Branch_ID(Branch_ID),
    .BranchTaken_ID(BranchTaken_ID), .MulDivStart_ID(MulDivStart_ID),
    .HiLoRead_ID(HiLoRead_ID), .WriteRegAddress_EX(WriteRegAddress_EX),
    .WriteRegAddress_MEM(WriteRegAddress_MEM), .RegWrite_EX(RegWrite_EX),
    .RegWrite_MEM(RegWrite_MEM), .MemRead_EX(MemRead_EX), .MemRead_MEM(MemRead_MEM),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXFlush(IDEXFlush),
    .IFIDFlush(IFIDFlush), .MulDivBusy(MulDivBusy), .StallCause(StallCause),
    .StallCycles(StallCycles)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation.
  hazard_stall_controller #(.MULDIV_LATENCY(4), .CNT_W(3)) dut_sat (
    .Clk(Clk), .Rst(Rst), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
    .UsesRs_ID(UsesRs_ID), .UsesRt_ID(UsesRt_ID), .Branch_ID(Branch_ID),
    .BranchTaken_ID(BranchTaken_ID), .MulDivStart_ID(MulDivStart_ID),
    .HiLoRead_ID(HiLoRead_ID), .WriteRegAddress_EX(WriteRegAddress_EX),
    .WriteRegAddress_MEM(WriteRegAddress_MEM), .RegWrite_EX(RegWrite_EX),
    .RegWrite_MEM(RegWrite_MEM), .MemRead_EX(MemRead_EX), .MemRead_MEM(MemRead_MEM),
    .PCWrite(sat_pc_write), .IFIDWrite(sat_ifid_write), .IDEXFlush(sat_idex_flush),
    .IFIDFlush(sat_ifid_flush), .MulDivBusy(sat_busy), .StallCause(sat_cause),
    .StallCycles(sat_cycles)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rs_ID = 5'd0; Rt_ID = 5'd0; UsesRs_ID = 1'b0; UsesRt_ID = 1'b0;
    Branch_ID = 1'b0; BranchTaken_ID = 1'b0; MulDivStart_ID = 1'b0; HiLoRead_ID = 1'b0;
    WriteRegAddress_EX = 5'd0; WriteRegAddress_MEM = 5'd0;
    RegWrite_EX = 1'b0; RegWrite_MEM = 1'b0; MemRead_EX = 1'b0; MemRead_MEM = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] addr);
    MemRead_EX = 1'b1; RegWrite_EX = 1'b1; WriteRegAddress_EX = addr;
    Rs_ID = addr; UsesRs_ID = 1'b1;
  endtask

  task automatic check_forced(input string tag);
    check({tag, "_pcw"},   32'(PCWrite),    32'd0);
    check({tag, "_ifidw"}, 32'(IFIDWrite),  32'd0);
    check({tag, "_idexf"}, 32'(IDEXFlush),  32'd1);
    check({tag, "_ifidf"}, 32'(IFIDFlush),  32'd1);
    check({tag, "_cause"}, 32'(StallCause), 32'd0);
  endtask

  task automatic check_stall(input string tag, input logic exp_stall, input logic [1:0] exp_cause);
    check({tag, "_pcw"},   32'(PCWrite),    32'(!exp_stall));
    check({tag, "_ifidw"}, 32'(IFIDWrite),  32'(!exp_stall));
    check({tag, "_idexf"}, 32'(IDEXFlush),  32'(exp_stall));
    check({tag, "_cause"}, 32'(StallCause), 32'(exp_cause));
  endtask

  initial begin
    Rst = 1'b1;
    clear_inputs();
    #1;
    tick();
    check_forced("rst");
    check("rst_cycles", StallCycles, 32'd0);
    check("rst_busy", 32'(MulDivBusy), 32'd0);

    Rst = 1'b0;
    #1;
    check_stall("idle", 1'b0, 2'd0);
    check("idle_ifidf", 32'(IFIDFlush), 32'd0);

    // Load-use on $8
    set_load_use(5'd8);
    #1;
    check_stall("lu", 1'b1, 2'd1);
    check("lu_cycles_before", StallCycles, 32'd0);
    tick();
    check("lu_cycles_after", StallCycles, 32'd1);

    // Same on $0, then a non-reading consumer: neither stalls
    set_load_use(5'd0);
    #1;
    check_stall("lu_r0", 1'b0, 2'd0);
    set_load_use(5'd8);
    UsesRs_ID = 1'b0;
    #1;
    check_stall("lu_unused", 1'b0, 2'd0);
    tick();
    check("lu_r0_cycles", StallCycles, 32'd1);

    // Branch depending on an ALU result in EX
    clear_inputs();
    Branch_ID = 1'b1; Rt_ID = 5'd9; UsesRt_ID = 1'b1;
    RegWrite_EX = 1'b1; WriteRegAddress_EX = 5'd9;
    #1;
    check_stall("br_ex", 1'b1, 2'd2);
    tick();
    WriteRegAddress_EX = 5'd3; RegWrite_MEM = 1'b1; WriteRegAddress_MEM = 5'd9;
    #1;
    check_stall("br_mem_alu", 1'b0, 2'd0);
    tick();

    // Branch depending on a load: EX-stage load, then MEM-stage load, then clear
    MemRead_EX = 1'b1; RegWrite_EX = 1'b1; WriteRegAddress_EX = 5'd9;
    RegWrite_MEM = 1'b0; WriteRegAddress_MEM = 5'd0;
    #1;
    check_stall("br_ld1", 1'b1, 2'd1);
    tick();
    MemRead_EX = 1'b0; RegWrite_EX = 1'b0; WriteRegAddress_EX = 5'd0;
    MemRead_MEM = 1'b1; RegWrite_MEM = 1'b1; WriteRegAddress_MEM = 5'd9;
    #1;
    check_stall("br_ld2", 1'b1, 2'd2);
    tick();
    MemRead_MEM = 1'b0; RegWrite_MEM = 1'b0; WriteRegAddress_MEM = 5'd0;
    #1;
    check_stall("br_ld3", 1'b0, 2'd0);
    check("br_cycles", StallCycles, 32'd4);

    // Taken branch flushes IF/ID unless stalled
    clear_inputs();
    BranchTaken_ID = 1'b1;
    #1;
    check("tk_ifidf", 32'(IFIDFlush), 32'd1);
    check("tk_pcw", 32'(PCWrite), 32'd1);
    tick();
    BranchTaken_ID = 1'b0;
    #1;
    check("tk_done_ifidf", 32'(IFIDFlush), 32'd0);
    BranchTaken_ID = 1'b1;
    set_load_use(5'd8);
    #1;
    check("tk_lu_ifidf", 32'(IFIDFlush), 32'd0);
    check_stall("tk_lu", 1'b1, 2'd1);
    tick();
    check("tk_cycles", StallCycles, 32'd5);

    // mult at cycle 0, mfhi waits through cycles 1-4, proceeds at cycle 5
    clear_inputs();
    MulDivStart_ID = 1'b1;
    #1;
    check_stall("md_issue", 1'b0, 2'd0);
    check("md_issue_busy", 32'(MulDivBusy), 32'd0);
    tick();
    MulDivStart_ID = 1'b0; HiLoRead_ID = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      #1;
      check_stall($sformatf("md_c%0d", c), 1'b1, 2'd3);
      check($sformatf("md_c%0d_busy", c), 32'(MulDivBusy), 32'd1);
      tick();
    end
    check_stall("md_c5", 1'b0, 2'd0);
    check("md_c5_busy", 32'(MulDivBusy), 32'd0);
    check("md_cycles", StallCycles, 32'd9);

    // Independent instruction behind a mult does not stall
    HiLoRead_ID = 1'b0; MulDivStart_ID = 1'b1;
    tick();
    MulDivStart_ID = 1'b0;
    #1;
    check_stall("md_indep", 1'b0, 2'd0);
    check("md_indep_busy", 32'(MulDivBusy), 32'd1);
    repeat (4) tick();
    check("md_drained", 32'(MulDivBusy), 32'd0);

    // mult stalled by load-use on its operand does not start the countdown
    set_load_use(5'd10);
    MulDivStart_ID = 1'b1;
    #1;
    check_stall("md_lu", 1'b1, 2'd1);
    tick();
    check("md_lu_busy", 32'(MulDivBusy), 32'd0);

    // Reset two cycles into a countdown
    clear_inputs();
    MulDivStart_ID = 1'b1;
    tick();
    MulDivStart_ID = 1'b0;
    tick();
    check("mr_busy_pre", 32'(MulDivBusy), 32'd1);
    Rst = 1'b1; HiLoRead_ID = 1'b1; BranchTaken_ID = 1'b1;
    #1;
    check_forced("mr_during");
    tick();
    check("mr_busy", 32'(MulDivBusy), 32'd0);
    check("mr_cycles", StallCycles, 32'd0);
    check("mr_sat_cycles", 32'(sat_cycles), 32'd0);
    check_forced("mr_held");
    Rst = 1'b0; BranchTaken_ID = 1'b0;
    #1;
    check_stall("mr_mfhi", 1'b0, 2'd0);

    // Hold a stall for 10 cycles: narrow counter sticks at 7
    set_load_use(5'd8);
    HiLoRead_ID = 1'b0;
    repeat (7) tick();
    check("sat_at7", 32'(sat_cycles), 32'd7);
    repeat (3) tick();
    check("sat_hold", 32'(sat_cycles), 32'd7);
    check("sat_wide", StallCycles, 32'd10);
    check("sat_cause", 32'(sat_cause), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
